// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller beside decode: 3-entry EX/MEM/WB destination scoreboard,
// forwarding selects, load-use stalls, branch flush, halt drain and statistics.
module pipeline_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic [REG_W-1:0] id_dest_i,
  input  logic             id_reg_write_i,
  input  logic             id_is_load_i,
  input  logic             id_is_halt_i,
  input  logic             ex_branch_taken_i,
  output logic             stall_if_o,
  output logic             bubble_id_o,
  output logic             flush_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic             halt_done_o,
  output logic [CNT_W-1:0] stall_count_o,
  output logic [CNT_W-1:0] hazard_count_o
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic             reg_write;
    logic             is_load;
  } sb_entry_t;

  sb_entry_t        ex_q, mem_q, wb_q, ex_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, haz_cnt_q, haz_cnt_d;

  logic in_run_s, load_use_s, stall_s, advance_s, hazard_s, sb_empty_s;
  logic rs_ex_s, rs_mem_s, rs_wb_s, rt_ex_s, rt_mem_s, rt_wb_s;

  // Register 0 is hardwired, so it never creates a dependence.
  function automatic logic sb_match(input sb_entry_t e, input logic [REG_W-1:0] r);
    return e.valid & e.reg_write & (e.dest == r) & (r != {REG_W{1'b0}});
  endfunction

  function automatic logic [1:0] fwd_sel(input logic ex_m, input logic ex_load,
                                         input logic mem_m, input logic wb_m);
    logic [1:0] sel;
    if (ex_m && !ex_load) begin
      sel = 2'b01;
    end else if (mem_m) begin
      sel = 2'b10;
    end else if (wb_m) begin
      sel = 2'b11;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  // Hazard detection, forwarding selects and next-state computation.
  always_comb begin
    rs_ex_s    = sb_match(ex_q, id_rs_i);
    rs_mem_s   = sb_match(mem_q, id_rs_i);
    rs_wb_s    = sb_match(wb_q, id_rs_i);
    rt_ex_s    = id_uses_rt_i & sb_match(ex_q, id_rt_i);
    rt_mem_s   = id_uses_rt_i & sb_match(mem_q, id_rt_i);
    rt_wb_s    = id_uses_rt_i & sb_match(wb_q, id_rt_i);
    in_run_s   = (state_q == ST_RUN);
    sb_empty_s = ~(ex_q.valid | mem_q.valid | wb_q.valid);
    load_use_s = in_run_s & id_valid_i & ex_q.is_load & (rs_ex_s | rt_ex_s);
    hazard_s   = rs_ex_s | rs_mem_s | rs_wb_s | rt_ex_s | rt_mem_s | rt_wb_s;
    // A taken branch kills the ID instruction, so it must not also stall.
    stall_s    = ~in_run_s | (load_use_s & ~ex_branch_taken_i);
    advance_s  = in_run_s & id_valid_i & ~stall_s & ~ex_branch_taken_i;

    fwd_a_o = fwd_sel(rs_ex_s, ex_q.is_load, rs_mem_s, rs_wb_s);
    if (id_uses_rt_i) begin
      fwd_b_o = fwd_sel(rt_ex_s, ex_q.is_load, rt_mem_s, rt_wb_s);
    end else begin
      fwd_b_o = 2'b00;
    end

    ex_d = '0;
    if (advance_s) begin
      ex_d.valid     = 1'b1;
      ex_d.dest      = id_dest_i;
      ex_d.reg_write = id_reg_write_i & ~id_is_halt_i;
      ex_d.is_load   = id_is_load_i & ~id_is_halt_i;
    end else begin
      ex_d = '0;
    end

    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (advance_s && id_is_halt_i) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (sb_empty_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_RUN;
    endcase

    if (load_use_s && !ex_branch_taken_i) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (advance_s && hazard_s) begin
      haz_cnt_d = sat_inc(haz_cnt_q);
    end else begin
      haz_cnt_d = haz_cnt_q;
    end
  end

  // Scoreboard shift, sequencing state and statistics registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      state_q     <= ST_RUN;
      stall_cnt_q <= {CNT_W{1'b0}};
      haz_cnt_q   <= {CNT_W{1'b0}};
    end else begin
      ex_q        <= ex_d;
      mem_q       <= ex_q;
      wb_q        <= mem_q;
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      haz_cnt_q   <= haz_cnt_d;
    end
  end

  assign stall_if_o     = stall_s;
  assign bubble_id_o    = stall_s;
  assign flush_o        = ex_branch_taken_i;
  assign halt_done_o    = (state_q == ST_DONE);
  assign stall_count_o  = stall_cnt_q;
  assign hazard_count_o = haz_cnt_q;

endmodule
